// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding controller
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_LU  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_LOAD_USE = 2'b01,
    CAUSE_SB       = 2'b10,
    CAUSE_STRUCT   = 2'b11
  } stall_cause_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-register vector and outstanding long-op counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int PCW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  issue_rd_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  lu_done,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  output logic [NUM_REGS-1:0]   sb_pending,
  output logic [PCW-1:0]        pending_cnt,
  output logic                  sb_err
);

  logic [NUM_REGS-1:0] pending_nxt;
  logic [PCW-1:0]      cnt_nxt;
  logic                done_ok;

  // A completion with nothing outstanding is spurious: it is flagged and does not move the count.
  assign done_ok = lu_done && (pending_cnt != '0);

  // Next pending vector and count; a clear and a set on different registers both apply.
  always_comb begin
    pending_nxt = sb_pending;
    if (lu_done && (lu_rd != '0)) pending_nxt[lu_rd] = 1'b0;
    if (issue && issue_rd_we && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
    cnt_nxt = pending_cnt;
    if (issue && !done_ok)      cnt_nxt = pending_cnt + PCW'(1);
    else if (!issue && done_ok) cnt_nxt = pending_cnt - PCW'(1);
  end

  // Scoreboard state registers; sb_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_pending  <= '0;
      pending_cnt <= '0;
      sb_err      <= 1'b0;
    end else begin
      sb_pending  <= pending_nxt;
      pending_cnt <= cnt_nxt;
      if (lu_done && (pending_cnt == '0)) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - operand forwarding, ID stall generation and stall perf counter
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int MAX_PENDING = 4,
  parameter int PERF_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]        id_rs,
  input  logic [NUM_SRC-1:0]                   id_rs_used,
  input  logic [REG_ADDR_W-1:0]                id_rd,
  input  logic                                 id_rd_we,
  input  logic                                 id_is_long,
  input  logic                                 flush,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]        ex_rs,
  input  logic [REG_ADDR_W-1:0]                ex_rd,
  input  logic                                 ex_reg_write,
  input  logic                                 ex_is_load,
  input  logic [REG_ADDR_W-1:0]                mem_rd,
  input  logic                                 mem_reg_write,
  input  logic [REG_ADDR_W-1:0]                wb_rd,
  input  logic                                 wb_reg_write,
  input  logic                                 lu_done,
  input  logic [REG_ADDR_W-1:0]                lu_rd,
  output logic [NUM_SRC*2-1:0]                 fwd_sel,
  output logic                                 stall,
  output logic [1:0]                           stall_cause,
  output logic [NUM_REGS-1:0]                  sb_pending,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_cnt,
  output logic                                 sb_err,
  output logic [PERF_W-1:0]                    perf_stall_cnt
);

  localparam int PCW = $clog2(MAX_PENDING + 1);
  localparam logic [PCW-1:0] MAX_CNT = PCW'(MAX_PENDING);

  logic [REG_ADDR_W-1:0] fsrc;
  fwd_sel_e              fsel;
  logic [REG_ADDR_W-1:0] isrc;
  logic                  load_use, sb_raw, sb_waw, structural;
  stall_cause_e          cause;
  logic                  issue;

  // Per-source bypass select: MEM beats long-unit beats WB; x0 is never forwarded.
  always_comb begin
    fwd_sel = '0;
    fsrc    = '0;
    fsel    = FWD_RF;
    for (int i = 0; i < NUM_SRC; i++) begin
      fsrc = ex_rs[REG_ADDR_W*i +: REG_ADDR_W];
      fsel = FWD_RF;
      if (fsrc != '0) begin
        if (mem_reg_write && (mem_rd == fsrc))     fsel = FWD_MEM;
        else if (lu_done && (lu_rd == fsrc))       fsel = FWD_LU;
        else if (wb_reg_write && (wb_rd == fsrc))  fsel = FWD_WB;
      end
      if (rst_n) fwd_sel[2*i +: 2] = fsel;
    end
  end

  // Hazard detection for the ID instruction, prioritised load-use > scoreboard > structural.
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    isrc     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      isrc = id_rs[REG_ADDR_W*i +: REG_ADDR_W];
      if (id_rs_used[i] && (isrc != '0)) begin
        if (ex_is_load && ex_reg_write && (ex_rd == isrc)) load_use = 1'b1;
        if (sb_pending[isrc]) sb_raw = 1'b1;
      end
    end
    sb_waw     = id_rd_we && (id_rd != '0) && sb_pending[id_rd];
    structural = id_is_long && (pending_cnt == MAX_CNT);
    cause      = CAUSE_NONE;
    if (id_valid && rst_n) begin
      if (load_use)              cause = CAUSE_LOAD_USE;
      else if (sb_raw || sb_waw) cause = CAUSE_SB;
      else if (structural)       cause = CAUSE_STRUCT;
    end
  end

  assign stall_cause = cause;
  assign stall       = (cause != CAUSE_NONE);
  assign issue       = id_valid && id_is_long && !stall && !flush;

  hazard_scoreboard #(
    .MAX_PENDING (MAX_PENDING),
    .PCW         (PCW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .issue_rd_we (id_rd_we),
    .issue_rd    (id_rd),
    .lu_done     (lu_done),
    .lu_rd       (lu_rd),
    .sb_pending  (sb_pending),
    .pending_cnt (pending_cnt),
    .sb_err      (sb_err)
  );

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                perf_stall_cnt <= '0;
    else if (stall && (perf_stall_cnt != '1))  perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_long;
  logic        flush;
  logic [9:0]  ex_rs;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        lu_done;
  logic [4:0]  lu_rd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [1:0]  stall_cause;
  logic [31:0] sb_pending;
  logic [2:0]  pending_cnt;
  logic        sb_err;
  logic [15:0] perf_stall_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  hazard_ctrl_unit #(.NUM_SRC(2), .MAX_PENDING(4), .PERF_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rs_used     (id_rs_used),
    .id_rd          (id_rd),
    .id_rd_we       (id_rd_we),
    .id_is_long     (id_is_long),
    .flush          (flush),
    .ex_rs          (ex_rs),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_is_load     (ex_is_load),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .lu_done        (lu_done),
    .lu_rd          (lu_rd),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .stall_cause    (stall_cause),
    .sb_pending     (sb_pending),
    .pending_cnt    (pending_cnt),
    .sb_err         (sb_err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_val(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic compare(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL no_expectation: observed %0h required none queued", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_bad++;
        $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_rd_we = 0;
    id_is_long = 0; flush = 0; ex_rs = '0; ex_rd = '0; ex_reg_write = 0;
    ex_is_load = 0; mem_rd = '0; mem_reg_write = 0; wb_rd = '0;
    wb_reg_write = 0; lu_done = 0; lu_rd = '0;
  endtask

  task automatic set_load_use();
    id_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd7;
    id_rs = {5'd7, 5'd3}; id_rs_used = 2'b11;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    id_valid = 1; id_is_long = 1; id_rd_we = 1; id_rd = rd; id_rs_used = '0;
    tick();
    id_valid = 0; id_is_long = 0; id_rd_we = 0; id_rd = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    set_load_use();
    #3;
    expect_val("rst_stall", 32'd0);     compare(32'(stall));
    expect_val("rst_fwd", 32'd0);       compare(32'(fwd_sel));
    expect_val("rst_pending", 32'd0);   compare(sb_pending);
    expect_val("rst_cnt", 32'd0);       compare(32'(pending_cnt));
    expect_val("rst_perf", 32'd0);      compare(32'(perf_stall_cnt));
    clear_inputs();
    #9 rst_n = 1;
    tick();

    mem_rd = 5'd5; wb_rd = 5'd5; lu_rd = 5'd5;
    mem_reg_write = 1; wb_reg_write = 1; lu_done = 1; ex_rs = {5'd0, 5'd5};
    expect_val("fwd_mem", 32'h2);       #1 compare(32'(fwd_sel));
    mem_reg_write = 0;
    expect_val("fwd_lu", 32'h3);        #1 compare(32'(fwd_sel));
    lu_done = 0;
    expect_val("fwd_wb", 32'h1);        #1 compare(32'(fwd_sel));
    ex_rs = {5'd0, 5'd0};
    expect_val("fwd_rf_x0", 32'h0);     #1 compare(32'(fwd_sel));
    ex_rs = {5'd5, 5'd0}; mem_reg_write = 1;
    expect_val("fwd_src1_mem", 32'h8);  #1 compare(32'(fwd_sel));
    mem_rd = 5'd0; ex_rs = {5'd0, 5'd0}; wb_reg_write = 0;
    expect_val("fwd_x0_never", 32'h0);  #1 compare(32'(fwd_sel));
    clear_inputs();
    tick();
    expect_val("no_err_after_fwd", 32'd0); compare(32'(sb_err));

    set_load_use();
    expect_val("lu_stall", 32'd1);      expect_val("lu_cause", 32'd1);
    #1 compare(32'(stall));             compare(32'(stall_cause));
    id_rs_used = 2'b01;
    expect_val("lu_unused_stall", 32'd0);
    #1 compare(32'(stall));
    id_rs_used = 2'b11;
    tick(); tick(); tick();
    clear_inputs();
    tick();
    expect_val("perf_three", 32'd3);    compare(32'(perf_stall_cnt));

    issue_long(5'd9);
    expect_val("div_cnt", 32'd1);       compare(32'(pending_cnt));
    expect_val("div_pending", 32'h200); compare(sb_pending);
    id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    expect_val("raw_stall", 32'd1);     expect_val("raw_cause", 32'd2);
    #1 compare(32'(stall));             compare(32'(stall_cause));
    id_rs_used = 2'b00; id_rd = 5'd9; id_rd_we = 1;
    expect_val("waw_cause", 32'd2);     #1 compare(32'(stall_cause));
    id_rd_we = 0; id_rd = '0; id_rs_used = 2'b01;
    lu_done = 1; lu_rd = 5'd9;
    expect_val("raw_hold_on_done", 32'd1); #1 compare(32'(stall));
    tick();
    lu_done = 0;
    expect_val("raw_release", 32'd0);   expect_val("div_cnt_zero", 32'd0);
    #1 compare(32'(stall));             compare(32'(pending_cnt));
    clear_inputs();

    for (int r = 1; r <= 4; r++) issue_long(5'(r));
    expect_val("full_cnt", 32'd4);      compare(32'(pending_cnt));
    expect_val("full_pending", 32'h1E); compare(sb_pending);
    id_valid = 1; id_is_long = 1; id_rd_we = 1; id_rd = 5'd5;
    expect_val("struct_stall", 32'd1);  expect_val("struct_cause", 32'd3);
    #1 compare(32'(stall));             compare(32'(stall_cause));
    id_rs = {5'd0, 5'd1}; id_rs_used = 2'b01;
    expect_val("prio_sb_over_struct", 32'd2); #1 compare(32'(stall_cause));
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd1;
    expect_val("prio_lu_over_sb", 32'd1);     #1 compare(32'(stall_cause));
    ex_is_load = 0; ex_reg_write = 0; ex_rd = '0; id_rs_used = 2'b00;
    lu_done = 1; lu_rd = 5'd1;
    tick();
    lu_done = 0;
    expect_val("done_with_stalled_cnt", 32'd3); compare(32'(pending_cnt));
    expect_val("struct_released", 32'd0);       #1 compare(32'(stall));
    tick();
    id_valid = 0; id_is_long = 0; id_rd_we = 0; id_rd = '0;
    expect_val("retry_cnt", 32'd4);     compare(32'(pending_cnt));
    expect_val("retry_pending", 32'h3C); compare(sb_pending);
    for (int r = 2; r <= 5; r++) begin
      lu_done = 1; lu_rd = 5'(r);
      tick();
    end
    clear_inputs();
    expect_val("drain_cnt", 32'd0);     compare(32'(pending_cnt));
    expect_val("drain_pending", 32'h0); compare(sb_pending);
    expect_val("drain_no_err", 32'd0);  compare(32'(sb_err));

    id_valid = 1; id_is_long = 1; id_rd_we = 1; id_rd = 5'd6; flush = 1;
    tick();
    clear_inputs();
    expect_val("flush_cnt", 32'd0);     compare(32'(pending_cnt));
    expect_val("flush_pending", 32'h0); compare(sb_pending);

    lu_done = 1; lu_rd = 5'd8;
    tick();
    lu_done = 0;
    expect_val("err_set", 32'd1);       compare(32'(sb_err));
    expect_val("err_cnt_zero", 32'd0);  compare(32'(pending_cnt));

    set_load_use();
    repeat (70000) @(posedge clk);
    #1;
    expect_val("perf_sat", 32'hFFFF);   compare(32'(perf_stall_cnt));
    tick();
    expect_val("perf_sat_hold", 32'hFFFF); compare(32'(perf_stall_cnt));
    clear_inputs();

    issue_long(5'd10);
    issue_long(5'd11);
    expect_val("mid_cnt", 32'd2);       compare(32'(pending_cnt));
    id_valid = 1; id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01;
    expect_val("mid_stall", 32'd1);     #1 compare(32'(stall));
    #1 rst_n = 0;
    expect_val("rst_mid_pending", 32'h0); expect_val("rst_mid_cnt", 32'd0);
    expect_val("rst_mid_stall", 32'd0);   expect_val("rst_mid_err", 32'd0);
    expect_val("rst_mid_perf", 32'd0);
    #1 compare(sb_pending);             compare(32'(pending_cnt));
    compare(32'(stall));                compare(32'(sb_err));
    compare(32'(perf_stall_cnt));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expectations: observed %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard and forwarding controller for the RV32IM pipeline. It replaces two-stage, two-source forwarding with N-source forwarding that includes a long-latency (MUL/DIV) result bypass. It adds load-use stall detection and a register scoreboard for outstanding multi-cycle operations. It sits beside the ID/EX stages: it drives the EX operand muxes and the ID/IF stall line.

## Interface
Parameters:
- NUM_SRC, 2, number of source operands per instruction
- MAX_PENDING, 4, max outstanding long-latency ops (≥1)
- PERF_W, 16, width of stall performance counter

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  valid instruction in ID
- id_rs  in  NUM_SRC*5  ID source register addresses, source i at [5i+4:5i]
- id_rs_used  in  NUM_SRC  source i actually read
- id_rd  in  5  ID destination
- id_rd_we  in  1  ID instruction writes rd
- id_is_long  in  1  ID instruction issues to long-latency unit
- flush  in  1  ID instruction is killed this cycle
- ex_rs  in  NUM_SRC*5  EX-stage source addresses
- ex_rd  in  5  EX destination
- ex_reg_write  in  1  EX writes rd
- ex_is_load  in  1  EX instruction is a load
- mem_rd, mem_reg_write  in  5, 1  EX/MEM destination and write enable
- wb_rd, wb_reg_write  in  5, 1  MEM/WB destination and write enable
- lu_done  in  1  long unit result valid (writes regfile this cycle)
- lu_rd  in  5  long unit destination
- fwd_sel  out  NUM_SRC*2  per-source operand select
- stall  out  1  hold IF/ID, bubble into EX
- stall_cause  out  2  reason for stall
- sb_pending  out  32  scoreboard bit vector
- pending_cnt  out  $clog2(MAX_PENDING+1)  outstanding long ops
- sb_err  out  1  sticky: lu_done with pending_cnt==0
- perf_stall_cnt  out  PERF_W  saturating stall-cycle count

## Operation
- Forwarding, per source i, with x0 never matching:
  - 10: mem_reg_write && mem_rd==ex_rs[i]
  - else 11: lu_done && lu_rd==ex_rs[i]
  - else 01: wb_reg_write && wb_rd==ex_rs[i]
  - else 00: register file value
- Stall conditions are evaluated only when id_valid. Source checks apply only to sources with id_rs_used set; x0 never matches.
  - load-use: ex_is_load && ex_reg_write && ex_rd matches an ID source.
  - scoreboard RAW: sb_pending[id_rs[i]] set.
  - scoreboard WAW: id_rd_we && sb_pending[id_rd].
  - structural: id_is_long && pending_cnt==MAX_PENDING.
- stall_cause: 00 none, 01 load-use, 10 scoreboard (RAW/WAW), 11 structural. Priority is 01 > 10 > 11.
- Issue = id_valid && id_is_long && !stall && !flush.
  - On issue, pending_cnt increments.
  - If id_rd_we and id_rd≠0, sb_pending[id_rd] is also set.
- On lu_done, pending_cnt decrements and sb_pending[lu_rd] clears (lu_rd≠0).
  - If pending_cnt==0, the count holds at 0 and sb_err sets.
- Issue and lu_done in the same cycle: the count holds and both bit updates apply. The same register cannot be issued and completed together because of the WAW stall.
- flush never clears scoreboard state; in-flight long ops always complete.
- perf_stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- fwd_sel, stall and stall_cause are combinational from the inputs and registered state, with zero latency.
- sb_pending, pending_cnt, sb_err and perf_stall_cnt are registered and update on the posedge of clk.
- A scoreboard bit set by an issue at edge k blocks ID from cycle k+1 onward.
- A bit cleared by lu_done in cycle k releases stall in cycle k+1. The result is in the register file by then.
- rst_n low clears all registers to 0 asynchronously; while in reset, stall=0 and fwd_sel=0.
  - Reset asserted mid-operation drops all pending ops. The long unit must be reset together with this block.

## Structure
- hazard_pkg holds:
  - fwd_sel_e: FWD_RF=00, FWD_WB=01, FWD_MEM=10, FWD_LU=11
  - stall_cause_e
  - REG_ADDR_W=5, NUM_REGS=32
- One sub-module, hazard_scoreboard, contains the 32-bit pending vector, the pending counter and sb_err.
- The top level holds the forward muxing, stall logic and perf counter.

## Test plan
- Forward priority: mem_rd=wb_rd=lu_rd=5, all writes active, ex_rs[0]=5 → fwd_sel[1:0]=10. With mem_reg_write=0 → 11. With lu_done=0 → 01. With ex_rs[0]=0 → 00.
- Load-use: ex_is_load=1, ex_rd=7, id_rs[1]=7 used → stall=1, cause=01. Same case with id_rs_used[1]=0 → stall=0.
- Scoreboard: issue a DIV with rd=9; next cycle id_rs[0]=9 → stall=1, cause=10. lu_done with lu_rd=9 → stall=0 the following cycle; pending_cnt returns to 0.
- Structural: issue 4 long ops to rd=1..4 → pending_cnt=4. A fifth long op stalls with cause=11. Simultaneous lu_done plus a stalled issue → count 3, then the issue proceeds.
- Flush and errors: flush on a long op → no count change. lu_done with count 0 → sb_err=1 and the count stays 0. 70000 stall cycles → perf_stall_cnt=16'hFFFF.
- Reset mid-op: 2 pending, rst_n low → sb_pending=0, pending_cnt=0 and stall=0 immediately.
